// File: rtl/i2c_reg_slave.sv
// I2C write-responder: acknowledges DEV_ADDR, turns each data byte into a one-cycle register write.
// Optional read path compiled in with `define I2C_SLAVE_READ_EN.
module i2c_reg_slave #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  output logic       oREG_WE,
  output logic [7:0] oREG_ADDR,
  output logic [7:0] oREG_DATA,
  output logic       oBUSY
`ifdef I2C_SLAVE_READ_EN
  ,
  input  logic [7:0] iREG_RDATA
`endif
);

  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV       = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_SUB       = 4'd3,
    ST_SUB_ACK   = 4'd4,
    ST_DATA      = 4'd5,
    ST_DATA_ACK  = 4'd6,
    ST_WAIT_STOP = 4'd7,
    ST_READ      = 4'd8,
    ST_READ_ACK  = 4'd9
  } state_t;

  logic [SYNC_N-1:0] scl_sync_r;
  logic [SYNC_N-1:0] sda_sync_r;
  logic              scl_hist_r;
  logic              sda_hist_r;
  logic              scl_s;
  logic              sda_s;
  logic              scl_rise_s;
  logic              scl_fall_s;
  logic              start_s;
  logic              stop_s;

  state_t            state_r;
  state_t            state_n;
  logic              sda_oe_r;
  logic              sda_oe_n;
  logic              busy_r;
  logic              busy_n;

  logic [7:0]        shift_r;
  logic [2:0]        bit_cnt_r;
  logic              byte_full_r;
  logic [7:0]        sub_addr_r;
  logic              we_r;
  logic [7:0]        reg_addr_r;
  logic [7:0]        reg_data_r;

  logic              shift_en_s;
  logic              clr_cnt_s;
  logic              load_sub_s;
  logic              wr_strobe_s;

`ifdef I2C_SLAVE_READ_EN
  logic              rd_mode_r;
  logic [7:0]        tx_r;
  logic              rd_sel_s;
  logic              rd_load_s;
  logic              rd_shift_s;
  logic              rd_inc_s;
`endif

  // Synchronizer chains plus one history flop per line for edge detection
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      scl_sync_r <= {SYNC_N{1'b1}};
      sda_sync_r <= {SYNC_N{1'b1}};
      scl_hist_r <= 1'b1;
      sda_hist_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_N-2:0], I2C_SCLK};
      sda_sync_r <= {sda_sync_r[SYNC_N-2:0], I2C_SDAT};
      scl_hist_r <= scl_sync_r[SYNC_N-1];
      sda_hist_r <= sda_sync_r[SYNC_N-1];
    end
  end

  assign scl_s      = scl_sync_r[SYNC_N-1];
  assign sda_s      = sda_sync_r[SYNC_N-1];
  assign scl_rise_s = scl_s & ~scl_hist_r;
  assign scl_fall_s = ~scl_s & scl_hist_r;
  // SDA moving while SCL is high is always a bus condition, never data
  assign start_s    = scl_s & sda_hist_r & ~sda_s;
  assign stop_s     = scl_s & ~sda_hist_r & sda_s;

  // State register, SDA drive enable and busy flag
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r  <= ST_IDLE;
      sda_oe_r <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_n;
      sda_oe_r <= sda_oe_n;
      busy_r   <= busy_n;
    end
  end

  // Next-state and datapath control decode
  always_comb begin
    state_n     = state_r;
    sda_oe_n    = sda_oe_r;
    busy_n      = busy_r;
    shift_en_s  = 1'b0;
    clr_cnt_s   = 1'b0;
    load_sub_s  = 1'b0;
    wr_strobe_s = 1'b0;
`ifdef I2C_SLAVE_READ_EN
    rd_sel_s    = 1'b0;
    rd_load_s   = 1'b0;
    rd_shift_s  = 1'b0;
    rd_inc_s    = 1'b0;
`endif
    if (start_s) begin
      state_n   = ST_DEV;
      clr_cnt_s = 1'b1;
      busy_n    = 1'b1;
      sda_oe_n  = 1'b0;
    end else if (stop_s) begin
      state_n   = ST_IDLE;
      clr_cnt_s = 1'b1;
      busy_n    = 1'b0;
      sda_oe_n  = 1'b0;
    end else begin
      case (state_r)
        ST_DEV, ST_SUB, ST_DATA: begin
          if (scl_rise_s) begin
            shift_en_s = 1'b1;
          end else if (scl_fall_s && byte_full_r) begin
            clr_cnt_s = 1'b1;
            sda_oe_n  = 1'b1;
            if (state_r == ST_DEV) begin
              if ((shift_r[7:1] == DEV_ADDR) && !shift_r[0]) begin
                state_n = ST_DEV_ACK;
`ifdef I2C_SLAVE_READ_EN
              end else if (shift_r[7:1] == DEV_ADDR) begin
                state_n  = ST_DEV_ACK;
                rd_sel_s = 1'b1;
`endif
              end else begin
                state_n  = ST_WAIT_STOP;
                sda_oe_n = 1'b0;
              end
            end else if (state_r == ST_SUB) begin
              state_n    = ST_SUB_ACK;
              load_sub_s = 1'b1;
            end else begin
              state_n     = ST_DATA_ACK;
              wr_strobe_s = 1'b1;
            end
          end else begin
            state_n = state_r;
          end
        end
        ST_DEV_ACK: begin
          if (scl_fall_s) begin
`ifdef I2C_SLAVE_READ_EN
            if (rd_mode_r) begin
              state_n   = ST_READ;
              rd_load_s = 1'b1;
              sda_oe_n  = ~iREG_RDATA[7];
            end else begin
              state_n  = ST_SUB;
              sda_oe_n = 1'b0;
            end
`else
            state_n  = ST_SUB;
            sda_oe_n = 1'b0;
`endif
          end else begin
            state_n = state_r;
          end
        end
        ST_SUB_ACK, ST_DATA_ACK: begin
          if (scl_fall_s) begin
            state_n  = (state_r == ST_SUB_ACK) ? ST_DATA : ST_DATA;
            sda_oe_n = 1'b0;
          end else begin
            state_n = state_r;
          end
        end
`ifdef I2C_SLAVE_READ_EN
        ST_READ: begin
          if (scl_rise_s) begin
            shift_en_s = 1'b1;
          end else if (scl_fall_s && byte_full_r) begin
            state_n   = ST_READ_ACK;
            clr_cnt_s = 1'b1;
            sda_oe_n  = 1'b0;
          end else if (scl_fall_s) begin
            rd_shift_s = 1'b1;
            sda_oe_n   = ~tx_r[6];
          end else begin
            state_n = state_r;
          end
        end
        ST_READ_ACK: begin
          // Master ACK advances the address; NACK ends the read
          if (scl_rise_s) begin
            if (!sda_s) begin
              rd_inc_s = 1'b1;
            end else begin
              state_n = ST_WAIT_STOP;
            end
          end else if (scl_fall_s) begin
            state_n   = ST_READ;
            rd_load_s = 1'b1;
            sda_oe_n  = ~iREG_RDATA[7];
          end else begin
            state_n = state_r;
          end
        end
`endif
        ST_IDLE, ST_WAIT_STOP: begin
          state_n = state_r;
        end
        default: begin
          state_n  = ST_IDLE;
          sda_oe_n = 1'b0;
          busy_n   = 1'b0;
        end
      endcase
    end
  end

  // Bit shifter, address register and write strobe
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      shift_r     <= 8'h00;
      bit_cnt_r   <= 3'd0;
      byte_full_r <= 1'b0;
      sub_addr_r  <= 8'h00;
      we_r        <= 1'b0;
      reg_addr_r  <= 8'h00;
      reg_data_r  <= 8'h00;
    end else begin
      we_r <= wr_strobe_s;
      if (clr_cnt_s) begin
        bit_cnt_r   <= 3'd0;
        byte_full_r <= 1'b0;
      end else if (shift_en_s) begin
        shift_r   <= {shift_r[6:0], sda_s};
        bit_cnt_r <= bit_cnt_r + 3'd1;
        if (bit_cnt_r == 3'd7) begin
          byte_full_r <= 1'b1;
        end
      end
      if (load_sub_s) begin
        sub_addr_r <= shift_r;
      end else if (wr_strobe_s) begin
        reg_addr_r <= sub_addr_r;
        reg_data_r <= shift_r;
        sub_addr_r <= sub_addr_r + 8'd1;
`ifdef I2C_SLAVE_READ_EN
      end else if (rd_sel_s) begin
        reg_addr_r <= sub_addr_r;
      end else if (rd_inc_s) begin
        sub_addr_r <= sub_addr_r + 8'd1;
        reg_addr_r <= sub_addr_r + 8'd1;
`endif
      end
    end
  end

`ifdef I2C_SLAVE_READ_EN
  // Read mode flag and transmit shifter
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rd_mode_r <= 1'b0;
      tx_r      <= 8'h00;
    end else begin
      if (start_s || stop_s) begin
        rd_mode_r <= 1'b0;
      end else if (rd_sel_s) begin
        rd_mode_r <= 1'b1;
      end
      if (rd_load_s) begin
        tx_r <= iREG_RDATA;
      end else if (rd_shift_s) begin
        tx_r <= {tx_r[6:0], 1'b0};
      end
    end
  end
`endif

  assign I2C_SDAT  = sda_oe_r ? 1'b0 : 1'bz;
  assign oREG_WE   = we_r;
  assign oREG_ADDR = reg_addr_r;
  assign oREG_DATA = reg_data_r;
  assign oBUSY     = busy_r;

endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: bit-banged I2C master, strobe monitor, hand-computed expectations.
module tb_i2c_reg_slave;

  localparam int Q = 10;

  logic       clk;
  logic       rst_n;
  logic       scl;
  logic       msda;
  wire        sda_bus;
  logic       reg_we;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic       busy;
`ifdef I2C_SLAVE_READ_EN
  logic [7:0] reg_rdata;
`endif

  int         n_checks;
  int         n_fail;
  int         we_cycles;
  logic       we_prev;
  logic       dut_low;
  logic [7:0] st_addr[$];
  logic [7:0] st_data[$];
  logic       ack;

  pullup (sda_bus);
  assign sda_bus = msda ? 1'bz : 1'b0;

  i2c_reg_slave dut (
    .iCLK      (clk),
    .iRST_N    (rst_n),
    .I2C_SCLK  (scl),
    .I2C_SDAT  (sda_bus),
    .oREG_WE   (reg_we),
    .oREG_ADDR (reg_addr),
    .oREG_DATA (reg_data),
    .oBUSY     (busy)
`ifdef I2C_SLAVE_READ_EN
    ,
    .iREG_RDATA(reg_rdata)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Strobe capture and detection of the slave pulling SDA low
  always @(negedge clk) begin
    #2;
    if (reg_we === 1'b1) begin
      we_cycles++;
      if (we_prev !== 1'b1) begin
        st_addr.push_back(reg_addr);
        st_data.push_back(reg_data);
      end
    end
    we_prev = reg_we;
    if (msda && sda_bus === 1'b0) dut_low = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    msda = 1'b1; wait_q();
    scl  = 1'b1; wait_q();
    msda = 1'b0; wait_q();
    scl  = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    msda = 1'b0; wait_q();
    scl  = 1'b1; wait_q();
    msda = 1'b1; wait_q();
  endtask

  task automatic send_bit(input logic b);
    msda = b;    wait_q();
    scl  = 1'b1; wait_q(); wait_q();
    scl  = 1'b0; wait_q();
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic ack_slot(output logic a, input logic drive_low);
    msda = ~drive_low; wait_q();
    scl  = 1'b1;       wait_q();
    a    = (sda_bus === 1'b0);
    wait_q();
    scl  = 1'b0;       wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    send_bits(b);
    ack_slot(a, 1'b0);
  endtask

  task automatic clear_mon();
    st_addr.delete();
    st_data.delete();
    we_cycles = 0;
    dut_low   = 1'b0;
  endtask

`ifdef I2C_SLAVE_READ_EN
  task automatic read_byte(output logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      msda = 1'b1; wait_q();
      scl  = 1'b1; wait_q();
      b[i] = sda_bus;
      wait_q();
      scl  = 1'b0; wait_q();
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    scl      = 1'b1;
    msda     = 1'b1;
    we_prev  = 1'b0;
    clear_mon();
`ifdef I2C_SLAVE_READ_EN
    reg_rdata = 8'hC5;
`endif
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    check_eq("rst_we",   reg_we,   1'b0);
    check_eq("rst_addr", reg_addr, 8'h00);
    check_eq("rst_data", reg_data, 8'h00);
    check_eq("rst_busy", busy,     1'b0);
    check_eq("rst_sda",  sda_bus,  1'b1);

    // Basic write: 34 0E 01
    clear_mon();
    i2c_start();
    check_eq("w1_busy_on", busy, 1'b1);
    send_byte(8'h34, ack); check_eq("w1_ack_dev",  ack, 1'b1);
    send_byte(8'h0E, ack); check_eq("w1_ack_sub",  ack, 1'b1);
    send_byte(8'h01, ack); check_eq("w1_ack_data", ack, 1'b1);
    i2c_stop();
    wait_q();
    check_eq("w1_busy_off", busy, 1'b0);
    check_eq("w1_nstrobe",  st_addr.size(), 1);
    check_eq("w1_we_width", we_cycles, 1);
    if (st_addr.size() == 1) begin
      check_eq("w1_addr", st_addr[0], 8'h0E);
      check_eq("w1_data", st_data[0], 8'h01);
    end

    // Foreign address: 40 15 00
    clear_mon();
    i2c_start();
    send_byte(8'h40, ack); check_eq("fa_ack_dev",  ack, 1'b0);
    send_byte(8'h15, ack); check_eq("fa_ack_sub",  ack, 1'b0);
    send_byte(8'h00, ack); check_eq("fa_ack_data", ack, 1'b0);
    i2c_stop();
    wait_q();
    check_eq("fa_nstrobe", st_addr.size(), 0);
    check_eq("fa_sda_low", dut_low, 1'b0);

    // Sub-address wrap: 34 FF AA 55
    clear_mon();
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'hFF, ack);
    send_byte(8'hAA, ack); check_eq("wr_ack_d0", ack, 1'b1);
    send_byte(8'h55, ack); check_eq("wr_ack_d1", ack, 1'b1);
    i2c_stop();
    wait_q();
    check_eq("wr_nstrobe", st_addr.size(), 2);
    check_eq("wr_we_cyc",  we_cycles, 2);
    if (st_addr.size() == 2) begin
      check_eq("wr_addr0", st_addr[0], 8'hFF);
      check_eq("wr_data0", st_data[0], 8'hAA);
      check_eq("wr_addr1", st_addr[1], 8'h00);
      check_eq("wr_data1", st_data[1], 8'h55);
    end

    // Partial byte cut by STOP, then a full frame
    clear_mon();
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h10, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    i2c_stop();
    wait_q();
    check_eq("pb_nstrobe", st_addr.size(), 0);
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h12, ack);
    send_byte(8'h01, ack);
    i2c_stop();
    wait_q();
    check_eq("pb_nstrobe2", st_addr.size(), 1);
    if (st_addr.size() == 1) begin
      check_eq("pb_addr", st_addr[0], 8'h12);
      check_eq("pb_data", st_data[0], 8'h01);
    end

    // Reset while the slave drives the data ACK
    clear_mon();
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h20, ack);
    send_bits(8'h77);
    msda = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("ra_sda_ack", sda_bus,  1'b0);
    check_eq("ra_addr",    reg_addr, 8'h20);
    check_eq("ra_data",    reg_data, 8'h77);
    rst_n = 1'b0;
    #1;
    check_eq("ra_sda_rel", sda_bus,  1'b1);
    check_eq("ra_we",      reg_we,   1'b0);
    check_eq("ra_addr0",   reg_addr, 8'h00);
    check_eq("ra_data0",   reg_data, 8'h00);
    check_eq("ra_busy0",   busy,     1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_q();
    i2c_stop();
    clear_mon();
    i2c_start();
    send_byte(8'h34, ack); check_eq("ra_re_ack", ack, 1'b1);
    send_byte(8'h05, ack);
    send_byte(8'h5A, ack);
    i2c_stop();
    wait_q();
    check_eq("ra_nstrobe", st_addr.size(), 1);
    if (st_addr.size() == 1) begin
      check_eq("ra_re_addr", st_addr[0], 8'h05);
      check_eq("ra_re_data", st_data[0], 8'h5A);
    end

`ifdef I2C_SLAVE_READ_EN
    begin
      logic [7:0] rb;
      clear_mon();
      i2c_start();
      send_byte(8'h35, ack); check_eq("rd_ack_dev", ack, 1'b1);
      read_byte(rb);
      check_eq("rd_byte", rb, 8'hC5);
      ack_slot(ack, 1'b0);
      send_byte(8'h00, ack); check_eq("rd_wait_noack", ack, 1'b0);
      check_eq("rd_busy", busy, 1'b1);
      i2c_stop();
      wait_q();
      check_eq("rd_we_cyc", we_cycles, 0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
